// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared definitions for the word-mux datapath blocks.
//
//   WORD_W  : default data word width in bits.
//   clog2() : constant function returning ceil(log2(n)), minimum 1, used
//             to size channel index fields.
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int WORD_W = 16;

    // Arbitration modes driven on i_mode.
    typedef enum logic {
        ARB_ROUND_ROBIN = 1'b0,
        ARB_FIXED       = 1'b1
    } arb_mode_e;

    // Width needed to index n items; a single item still gets one bit so
    // that index fields never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : cpu_defs

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin / fixed-priority request arbiter with a rotating pointer.
//
//   Ports
//     i_clk        : clock, state updates on rising edge
//     i_rst_n      : asynchronous active-low reset (pointer returns to 0)
//     i_mode       : 0 = round-robin from pointer, 1 = lowest index wins
//     i_valid      : per-channel requests, bit k = channel k
//     i_advance    : a transfer happens this cycle on the granted channel
//     o_grant      : one-hot grant (all zero when nothing requests)
//     o_grant_idx  : binary index of the granted channel (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
    import cpu_defs::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = clog2(CHANNELS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_mode,
    input  logic [0:CHANNELS-1] i_valid,
    input  logic                i_advance,
    output logic [0:CHANNELS-1] o_grant,
    output logic [SEL_W-1:0]    o_grant_idx
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_found;

    // Search CHANNELS candidates starting at the pointer (round-robin) or
    // at 0 (fixed). The first requesting candidate wins. The wrap is done
    // by subtraction rather than modulo so that non-power-of-two channel
    // counts never produce an index >= CHANNELS.
    always_comb begin
        int cand;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = 0;
        for (int off = 0; off < CHANNELS; off++) begin
            if (i_mode == ARB_FIXED) begin
                cand = off;
            end else begin
                cand = int'(ptr_q) + off;
                if (cand >= CHANNELS) begin
                    cand = cand - CHANNELS;
                end
            end
            if (!grant_found && i_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SEL_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_grant
            assign o_grant[gi] = grant_found && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    assign o_grant_idx = grant_idx;

    // Pointer moves past the winner only on a round-robin transfer; fixed
    // mode leaves it untouched so switching back resumes where it was.
    always_comb begin
        ptr_d = ptr_q;
        if (i_advance && grant_found && (i_mode == ARB_ROUND_ROBIN)) begin
            if (grant_idx == LAST_IDX) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/rr_wordmux.sv
// ---------------------------------------------------------------------------
// rr_wordmux
//   CHANNELS:1 word multiplexer with arbitration and a single registered
//   output stage using valid/ready handshakes on both sides.
//
//   Ports
//     i_clk    : clock, state updates on rising edge
//     i_rst_n  : asynchronous active-low reset
//     i_mode   : 0 = round-robin, 1 = fixed priority (lowest index)
//     i_valid  : per-channel request, bit k = channel k
//     i_data   : channel words, channel k at [k*WIDTH : k*WIDTH+WIDTH-1]
//     o_ready  : per-channel accept strobe (one-hot or zero)
//     o_valid  : output register holds a word
//     o_data   : registered selected word
//     o_sel    : registered index of the channel that supplied o_data
//     i_ready  : downstream accept for o_data
// ---------------------------------------------------------------------------
module rr_wordmux
    import cpu_defs::*;
#(
    parameter int WIDTH    = WORD_W,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mode,
    input  logic [0:CHANNELS-1]       i_valid,
    input  logic [0:CHANNELS*WIDTH-1] i_data,
    output logic [0:CHANNELS-1]       o_ready,
    output logic                      o_valid,
    output logic [0:WIDTH-1]          o_data,
    output logic [0:SEL_W-1]          o_sel,
    input  logic                      i_ready
);

    // The select table is padded to a power of two so every value of the
    // index field addresses a defined entry.
    localparam int TABLE_N = 1 << SEL_W;

    logic                  valid_q;
    logic                  valid_d;
    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      data_d;
    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      sel_d;

    logic                  load;
    logic                  any_valid;
    logic                  transfer;
    logic [0:CHANNELS-1]   arb_grant;
    logic [SEL_W-1:0]      arb_grant_idx;
    logic [WIDTH-1:0]      words [TABLE_N];
    logic [WIDTH-1:0]      sel_word;

    // Output register may take a new word when it is empty or being
    // drained this cycle; i_ready only reaches o_ready, never o_data or
    // o_valid directly.
    assign load      = !valid_q || i_ready;
    assign any_valid = |i_valid;
    assign transfer  = load && any_valid;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arbiter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_mode      (i_mode),
        .i_valid     (i_valid),
        .i_advance   (transfer),
        .o_grant     (arb_grant),
        .o_grant_idx (arb_grant_idx)
    );

    // Accept strobes are suppressed while reset is held so nothing upstream
    // sees a handshake that the registers would discard.
    assign o_ready = arb_grant & {CHANNELS{load && i_rst_n}};

    genvar gi;
    generate
        for (gi = 0; gi < TABLE_N; gi++) begin : g_words
            if (gi < CHANNELS) begin : g_live
                assign words[gi] = i_data[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign words[gi] = '0;
            end
        end
    endgenerate

    assign sel_word = words[arb_grant_idx];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            if (any_valid) begin
                valid_d = 1'b1;
                data_d  = sel_word;
                sel_d   = arb_grant_idx;
            end else begin
                // Nothing to load: drop valid but keep the last word/index.
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_sel   = sel_q;

endmodule : rr_wordmux

// File: tb/tb_rr_wordmux.sv
module tb_rr_wordmux;

    logic        clk;
    logic        rst_n;

    // 4-channel instance
    logic        mode4;
    logic [0:3]  valid4;
    logic [0:63] data4;
    logic [0:3]  ready4_o;
    logic        ovalid4;
    logic [0:15] odata4;
    logic [0:1]  osel4;
    logic        iready4;

    // 3-channel instance
    logic        mode3;
    logic [0:2]  valid3;
    logic [0:47] data3;
    logic [0:2]  ready3_o;
    logic        ovalid3;
    logic [0:15] odata3;
    logic [0:1]  osel3;
    logic        iready3;

    logic [15:0] w0, w1, w2, w3;

    int vectors;
    int miscompares;

    assign data4 = {w0, w1, w2, w3};
    assign data3 = {16'hC000, 16'hC001, 16'hC002};

    rr_wordmux u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mode  (mode4),
        .i_valid (valid4),
        .i_data  (data4),
        .o_ready (ready4_o),
        .o_valid (ovalid4),
        .o_data  (odata4),
        .o_sel   (osel4),
        .i_ready (iready4)
    );

    rr_wordmux #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mode  (mode3),
        .i_valid (valid3),
        .i_data  (data3),
        .o_ready (ready3_o),
        .o_valid (ovalid3),
        .o_data  (odata3),
        .o_sel   (osel3),
        .i_ready (iready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
    endtask

    // Advance one clock and settle 2 time units past the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out4(input string tag, input logic v, input logic [15:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 64'(ovalid4), 64'(v));
        chk({tag, ".data"},  64'(odata4),  64'(d));
        chk({tag, ".sel"},   64'(osel4),   64'(s));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        w0 = 16'h1000; w1 = 16'h2111; w2 = 16'h3222; w3 = 16'h4333;
        rst_n   = 1'b1;
        mode4   = 1'b0; valid4 = 4'b1111; iready4 = 1'b1;
        mode3   = 1'b0; valid3 = 3'b111;  iready3 = 1'b1;

        // Reset asserted before any clock edge: outputs cleared at once.
        #1 rst_n = 1'b0;
        #1;
        chk_out4("rst_noclk", 1'b0, 16'h0000, 2'd0);
        chk("rst_noclk.ready", 64'(ready4_o), 64'(4'b0000));

        // Clocks while in reset do not load anything.
        tick();
        tick();
        chk_out4("rst_clk", 1'b0, 16'h0000, 2'd0);
        chk("rst_clk.ready", 64'(ready4_o), 64'(4'b0000));
        chk("rst_clk.ready3", 64'(ready3_o), 64'(3'b000));

        // Release; round-robin starts at channel 0.
        rst_n = 1'b1;
        #1;
        chk("rr.ready0", 64'(ready4_o), 64'(4'b1000));

        // Round-robin, all valid, always ready: 0,1,2,3,0.
        tick(); chk_out4("rr.t1", 1'b1, 16'h1000, 2'd0);
        chk("rr.t1.ready", 64'(ready4_o), 64'(4'b0100));
        chk("c3.t1.sel", 64'(osel3), 64'(2'd0));
        tick(); chk_out4("rr.t2", 1'b1, 16'h2111, 2'd1);
        chk("c3.t2.sel", 64'(osel3), 64'(2'd1));
        tick(); chk_out4("rr.t3", 1'b1, 16'h3222, 2'd2);
        chk("c3.t3.sel", 64'(osel3), 64'(2'd2));
        chk("c3.t3.data", 64'(odata3), 64'(16'hC002));
        tick(); chk_out4("rr.t4", 1'b1, 16'h4333, 2'd3);
        chk("c3.t4.sel", 64'(osel3), 64'(2'd0));
        chk("c3.t4.data", 64'(odata3), 64'(16'hC000));
        tick(); chk_out4("rr.t5", 1'b1, 16'h1000, 2'd0);
        chk("c3.t5.sel", 64'(osel3), 64'(2'd1));
        // ptr now 1

        // Fixed priority with channels 1 and 2 requesting: always 1.
        mode4 = 1'b1; valid4 = 4'b0110;
        #1;
        chk("fix.ready", 64'(ready4_o), 64'(4'b0100));
        tick(); chk_out4("fix.t1", 1'b1, 16'h2111, 2'd1);
        chk("fix.t1.ready2", 64'(ready4_o[2]), 64'(1'b0));
        tick(); chk_out4("fix.t2", 1'b1, 16'h2111, 2'd1);
        chk("fix.t2.ready2", 64'(ready4_o[2]), 64'(1'b0));
        tick(); chk_out4("fix.t3", 1'b1, 16'h2111, 2'd1);

        // Back to round-robin: pointer (1) was kept through fixed mode.
        mode4 = 1'b0; valid4 = 4'b1111;
        #1;
        chk("mode.ready", 64'(ready4_o), 64'(4'b0100));
        tick(); chk_out4("mode.t1", 1'b1, 16'h2111, 2'd1);
        // ptr now 2

        // Backpressure for three cycles: hold output, no accepts.
        iready4 = 1'b0;
        #1;
        chk("bp.ready", 64'(ready4_o), 64'(4'b0000));
        tick(); chk_out4("bp.t1", 1'b1, 16'h2111, 2'd1);
        tick(); chk_out4("bp.t2", 1'b1, 16'h2111, 2'd1);
        tick(); chk_out4("bp.t3", 1'b1, 16'h2111, 2'd1);
        chk("bp.t3.ready", 64'(ready4_o), 64'(4'b0000));
        iready4 = 1'b1;
        #1;
        chk("bp.release.ready", 64'(ready4_o), 64'(4'b0010));
        tick(); chk_out4("bp.load", 1'b1, 16'h3222, 2'd2);
        // ptr now 3

        // Load A5A5 from channel 3, then go idle: valid drops, data held.
        w3 = 16'hA5A5;
        tick(); chk_out4("idle.load", 1'b1, 16'hA5A5, 2'd3);
        // ptr now 0
        valid4 = 4'b0000;
        #1;
        chk("idle.ready", 64'(ready4_o), 64'(4'b0000));
        tick(); chk_out4("idle.t1", 1'b0, 16'hA5A5, 2'd3);
        tick(); chk_out4("idle.t2", 1'b0, 16'hA5A5, 2'd3);

        // Bring ptr to 2 with o_valid=1, then pulse reset between edges.
        valid4 = 4'b1111;
        tick(); chk_out4("ar.pre1", 1'b1, 16'h1000, 2'd0);
        tick(); chk_out4("ar.pre2", 1'b1, 16'h2111, 2'd1);
        rst_n = 1'b0;
        #1;
        chk_out4("ar.low", 1'b0, 16'h0000, 2'd0);
        chk("ar.low.ready", 64'(ready4_o), 64'(4'b0000));
        #1 rst_n = 1'b1;
        #1;
        chk("ar.rel.ready", 64'(ready4_o), 64'(4'b1000));
        tick(); chk_out4("ar.first", 1'b1, 16'h1000, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_rr_wordmux
